// File: rtl/counter16_sched_2req.sv
// counter16_sched_2req: a single shared up-counter handed out to two
// requesters by a round-robin arbiter. Each grant loads the owner's terminal
// count, runs the counter from 0 up to that limit, pulses the owner's done
// for one cycle and then releases the counter.
// All state changes happen on the falling edge of clock0. reset is
// asynchronous and active-low.
// Optional feature: define COUNTER_SCHED_ABORT_EN to add an abort input that
// ends a run early, plus an aborted flag that accompanies the done pulse.
module counter16_sched_2req #(
  parameter int WIDTH = 16
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, next_state;
  logic [WIDTH-1:0] count_q, next_count;
  logic [WIDTH-1:0] limit_q, next_limit;
  // owner_q / last_q: 0 means requester 0, 1 means requester 1
  logic             owner_q, next_owner;
  logic             last_q, next_last;
  logic             run_abort;

`ifdef COUNTER_SCHED_ABORT_EN
  logic aborted_q;

  assign run_abort = abort;

  // Flag an early exit: set only when a RUN edge is cut short, so it is high exactly for that DONE cycle
  always_ff @(negedge clock0 or negedge reset) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= (state == RUN) && abort;
    end
  end

  assign aborted = aborted_q;
`else
  assign run_abort = 1'b0;
`endif

  // State register; reset drops straight to IDLE so grants and dones vanish at once
  always_ff @(negedge clock0 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers; last_q starts at 1 so requester 0 wins the first tie
  always_ff @(negedge clock0 or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      limit_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      count_q <= next_count;
      limit_q <= next_limit;
      owner_q <= next_owner;
      last_q  <= next_last;
    end
  end

  // Arbitration, counting and output decode
  always_comb begin
    next_state = state;
    next_count = count_q;
    next_limit = limit_q;
    next_owner = owner_q;
    next_last  = last_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          next_state = RUN;
          next_count = '0;
          if (req0 && req1) begin
            next_owner = ~last_q;
          end else begin
            next_owner = req1;
          end
          next_limit = next_owner ? len1 : len0;
        end
      end
      RUN: begin
        busy = 1'b1;
        gnt0 = ~owner_q;
        gnt1 = owner_q;
        if (run_abort || (count_q == limit_q)) begin
          next_state = DONE;
        end else begin
          next_count = count_q + ONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        gnt0       = ~owner_q;
        gnt1       = owner_q;
        done0      = ~owner_q;
        done1      = owner_q;
        next_state = IDLE;
        next_last  = owner_q;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter16_sched_2req.sv
// tb_counter16_sched_2req: directed checks of the two-requester counter
// scheduler with hand-computed expectations. Inputs change and outputs are
// sampled 1 time unit after each falling edge of clock0.
// Define COUNTER_SCHED_ABORT_EN to also exercise the abort feature.
module tb_counter16_sched_2req;

  logic        clock0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] len0, len1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] count;
`ifdef COUNTER_SCHED_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int total;
  int bad;

  counter16_sched_2req #(.WIDTH(16)) dut (
    .clock0 (clock0),
    .reset  (reset),
    .req0   (req0),
    .len0   (len0),
    .req1   (req1),
    .len1   (len1),
`ifdef COUNTER_SCHED_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .busy   (busy),
    .count  (count)
  );

  // Free-running clock; the active edge is the falling one
  initial begin
    clock0 = 1'b1;
    forever #5 clock0 = ~clock0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [15:0] l0,
                               input logic r1, input logic [15:0] l1);
    req0 = r0;
    len0 = l0;
    req1 = r1;
    len1 = l1;
  endtask

  task automatic tick();
    @(negedge clock0);
    #1;
  endtask

  task automatic checkIdle(input string tag, input logic [15:0] exp_count);
    checkOutput({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
    checkOutput({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
    checkOutput({tag, "_done0"}, {31'd0, done0}, 32'd0);
    checkOutput({tag, "_done1"}, {31'd0, done1}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_count"}, {16'd0, count}, {16'd0, exp_count});
  endtask

  initial begin
    int n;
    int done_pulses;
    logic wrapped;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
`ifdef COUNTER_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    checkIdle("reset", 16'd0);
    tick();
    reset = 1'b1;

    // Scenario 1: req0 alone, len0=3; len and req changes during RUN are ignored
    applyStimulus(1'b1, 16'd3, 1'b0, 16'd0);
    tick();
    checkOutput("s1_gnt0", {31'd0, gnt0}, 32'd1);
    checkOutput("s1_busy", {31'd0, busy}, 32'd1);
    checkOutput("s1_count0", {16'd0, count}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("s1_count", {16'd0, count}, i);
      checkOutput("s1_nodone", {31'd0, done0}, 32'd0);
    end
    tick();
    checkOutput("s1_done0", {31'd0, done0}, 32'd1);
    checkOutput("s1_done1", {31'd0, done1}, 32'd0);
    checkOutput("s1_gnt0_done", {31'd0, gnt0}, 32'd1);
    checkOutput("s1_hold", {16'd0, count}, 32'd3);
    tick();
    checkIdle("s1_idle", 16'd3);

    // Scenario 3: len1=0 finishes one edge after grant
    applyStimulus(1'b0, 16'd0, 1'b1, 16'd0);
    tick();
    checkOutput("s3_gnt1", {31'd0, gnt1}, 32'd1);
    checkOutput("s3_gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("s3_count", {16'd0, count}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    checkOutput("s3_done1", {31'd0, done1}, 32'd1);
    checkOutput("s3_done0", {31'd0, done0}, 32'd0);
    checkOutput("s3_count_done", {16'd0, count}, 32'd0);
    tick();
    checkIdle("s3_idle", 16'd0);

    // Scenario 2: from reset, both requesting with len=2 alternate 0,1,0,1
    reset = 1'b0;
    #1;
    checkIdle("s2_reset", 16'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 16'd2, 1'b1, 16'd2);
    for (int r = 0; r < 4; r++) begin
      logic exp1;
      exp1 = (r % 2) == 1;
      tick();
      checkOutput("s2_gnt0", {31'd0, gnt0}, {31'd0, ~exp1});
      checkOutput("s2_gnt1", {31'd0, gnt1}, {31'd0, exp1});
      checkOutput("s2_count0", {16'd0, count}, 32'd0);
      tick();
      tick();
      checkOutput("s2_count2", {16'd0, count}, 32'd2);
      checkOutput("s2_both", {31'd0, gnt0 & gnt1}, 32'd0);
      tick();
      checkOutput("s2_done0", {31'd0, done0}, {31'd0, ~exp1});
      checkOutput("s2_done1", {31'd0, done1}, {31'd0, exp1});
      tick();
      checkOutput("s2_idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("s2_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    end
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    tick();

    // Scenario 5: reset in the middle of a len0=10 run, then req1 alone
    applyStimulus(1'b1, 16'd10, 1'b0, 16'd0);
    tick();
    checkOutput("s5_gnt0", {31'd0, gnt0}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("s5_count5", {16'd0, count}, 32'd5);
    reset = 1'b0;
    #1;
    checkIdle("s5_reset", 16'd0);
    tick();
    checkIdle("s5_held", 16'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 16'd10, 1'b1, 16'd1);
    tick();
    checkOutput("s5_gnt1", {31'd0, gnt1}, 32'd1);
    checkOutput("s5_gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("s5_nodone0", {31'd0, done0}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    checkOutput("s5_count1", {16'd0, count}, 32'd1);
    tick();
    checkOutput("s5_done1", {31'd0, done1}, 32'd1);
    tick();
    checkIdle("s5_idle", 16'd1);

    // Scenario 4: len0=0xFFFF counts to all-ones without wrapping
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 16'd0);
    tick();
    checkOutput("s4_gnt0", {31'd0, gnt0}, 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    n = 0;
    done_pulses = 0;
    wrapped = 1'b0;
    while (n < 70000 && !done0) begin
      tick();
      n++;
      if (count == 16'd0) wrapped = 1'b1;
    end
    checkOutput("s4_edges", n, 32'h10000);
    checkOutput("s4_wrap", {31'd0, wrapped}, 32'd0);
    checkOutput("s4_count", {16'd0, count}, 32'hFFFF);
    if (done0) done_pulses++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done0) done_pulses++;
    end
    checkOutput("s4_pulses", done_pulses, 32'd1);
    checkIdle("s4_idle", 16'hFFFF);

`ifdef COUNTER_SCHED_ABORT_EN
    // Scenario 6: abort at count=4 of a len0=9 run
    applyStimulus(1'b1, 16'd9, 1'b0, 16'd0);
    tick();
    checkOutput("s6_gnt0", {31'd0, gnt0}, 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("s6_count4", {16'd0, count}, 32'd4);
    checkOutput("s6_aborted_pre", {31'd0, aborted}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("s6_done0", {31'd0, done0}, 32'd1);
    checkOutput("s6_aborted", {31'd0, aborted}, 32'd1);
    checkOutput("s6_hold", {16'd0, count}, 32'd4);
    tick();
    checkOutput("s6_aborted_post", {31'd0, aborted}, 32'd0);
    checkIdle("s6_idle", 16'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
